// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes, SR/Cause field positions
// and the two-mode trap state type.
package cp0_exc_unit_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD_BIT = 31;

  typedef enum logic {
    MODE_NORMAL     = 1'b0,
    MODE_IN_HANDLER = 1'b1
  } mode_t;

endpackage

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt unit: trap decision, SR/Cause/EPC/PRId, mfc0/mtc0, eret.
// Optional BadVAddr register enabled by defining CP0_BADVADDR_EN.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h2024_1029
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] badvaddr_in,
`endif
  output logic        req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out
);

  mode_t       mode_q, mode_d;
  logic        exl;
  logic        ie;
  logic [5:0]  im;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;
  logic        int_req;
  logic        exc_req;
  logic        sr_we;
  logic        epc_we;
`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr;
`endif

  function automatic logic [31:0] trap_epc(input logic [31:0] pc, input logic in_bd);
    logic [31:0] t;
    t = in_bd ? pc - 32'd4 : pc;
    return {t[31:2], 2'b00};
  endfunction

  assign exl     = (mode_q == MODE_IN_HANDLER);
  assign int_req = ie & ~exl & (|(hw_int & im));
  assign exc_req = ~exl & (exc_code_in != EXC_INT);
  // A trap seen while reset is asserted is dropped rather than deferred.
  assign req     = ~reset & (int_req | exc_req);

  assign sr_we  = we & ~req & (cp0_addr == REG_SR);
  assign epc_we = we & ~req & (cp0_addr == REG_EPC);

  assign handler_pc = HANDLER_PC;
  assign epc_out    = epc;

  always_ff @(posedge clk) begin
    if (reset) mode_q <= MODE_NORMAL;
    else       mode_q <= mode_d;
  end

  // eret is evaluated after an SR write so it always leaves the handler.
  always_comb begin
    mode_d = mode_q;
    if (req) begin
      mode_d = MODE_IN_HANDLER;
    end else begin
      if (sr_we) mode_d = cp0_wdata[SR_EXL_BIT] ? MODE_IN_HANDLER : MODE_NORMAL;
      if (eret)  mode_d = MODE_NORMAL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie       <= 1'b0;
      im       <= '0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= hw_int;
      if (req) begin
        bd       <= bd_in;
        exc_code <= int_req ? EXC_INT : exc_code_in;
        epc      <= trap_epc(vpc, bd_in);
      end else begin
        if (sr_we) begin
          ie <= cp0_wdata[SR_IE_BIT];
          im <= cp0_wdata[SR_IM_HI:SR_IM_LO];
        end
        if (epc_we) epc <= {cp0_wdata[31:2], 2'b00};
      end
    end
  end

`ifdef CP0_BADVADDR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr <= '0;
    end else if (req && !int_req &&
                 (exc_code_in == EXC_ADEL || exc_code_in == EXC_ADES)) begin
      badvaddr <= badvaddr_in;
    end
  end
`endif

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      REG_SR: begin
        cp0_rdata[SR_IM_HI:SR_IM_LO] = im;
        cp0_rdata[SR_EXL_BIT]        = exl;
        cp0_rdata[SR_IE_BIT]         = ie;
      end
      REG_CAUSE: begin
        cp0_rdata[CAUSE_BD_BIT]              = bd;
        cp0_rdata[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
        cp0_rdata[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code;
      end
      REG_EPC:  cp0_rdata = epc;
      REG_PRID: cp0_rdata = PRID;
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: cp0_rdata = badvaddr;
`endif
      default: cp0_rdata = '0;
    endcase
  end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
Coprocessor-0 exception/interrupt unit at the M-stage end of the pipeline. It consumes the 5-bit ExcCode that the E-stage ALU and earlier stages produce, and samples the external hardware interrupt lines. It decides whether to take a trap, records SR/Cause/EPC, and drives the flush request and handler PC to the fetch stage. It also serves mfc0/mtc0 and eret.

Parameters:
HANDLER_PC, 32'h0000_4180, fetch target on any taken trap
PRID, 32'h2024_1029, read-only processor ID value (reg 15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
we  in  1  mtc0 write enable (M stage)
cp0_addr  in  5  CP0 register number for mfc0/mtc0
cp0_wdata  in  32  mtc0 data
cp0_rdata  out  32  mfc0 data, combinational from cp0_addr
vpc  in  32  PC of the M-stage instruction
bd_in  in  1  M-stage instruction is in a branch delay slot
exc_code_in  in  5  pipelined ExcCode from E stage; 0 = no exception
hw_int  in  6  external interrupt lines, level-sensitive
eret  in  1  M-stage instruction is eret
req  out  1  take trap this cycle; flush F/D/E/M and redirect
handler_pc  out  32  constant HANDLER_PC
epc_out  out  32  current EPC value, used as the eret target

Behaviour:
- Registers: SR (12) holds IM[15:10], EXL[1] and IE[0]; all other SR bits read 0. Cause (13) holds BD[31], IP[15:10] and ExcCode[6:2]; all other Cause bits read 0. EPC (14) is 32 bits. PRId (15) is the PRID constant.
- Reset: SR, Cause and EPC clear to 0 at the clock edge where reset=1. req=0 during reset. A trap that is pending in a reset cycle is discarded.
- int_req = IE & ~EXL & |(hw_int & IM). exc_req = ~EXL & (exc_code_in != 0). req = int_req | exc_req, combinational, same cycle.
- Priority: an interrupt beats an exception. On int_req the recorded ExcCode is 0; otherwise it is exc_code_in.
- At the edge where req=1:
  - EXL <= 1.
  - Cause.BD <= bd_in.
  - Cause.ExcCode is updated as above.
  - EPC <= bd_in ? vpc-4 : vpc, with bits [1:0] forced to 0.
- Cause.IP <= hw_int every cycle, unconditionally, including while EXL=1.
- mtc0 (we=1, req=0):
  - addr 12 writes IM, EXL and IE only.
  - addr 14 writes EPC[31:2]; EPC[1:0] stays 0.
  - Writes to 13, 15 or unmapped addresses are ignored.
  - When we and req are both 1, req wins and the write is dropped.
- eret (eret=1, req=0): EXL <= 0 at the edge. If eret and req are both 1, req wins and EXL stays 1.
- Nested traps: while EXL=1, req is forced to 0 and exc_code_in is ignored. No trap state changes except Cause.IP.
- cp0_rdata returns the pre-edge value, with no write forwarding. Unmapped addresses read 0.
- One state bit (EXL) gives the two modes NORMAL and IN_HANDLER. NORMAL goes to IN_HANDLER on req. IN_HANDLER goes back to NORMAL on eret, or on an mtc0 that clears EXL.

Optional Feature:
CP0_BADVADDR_EN.
- Defined:
  - Adds input badvaddr_in[31:0] and register BadVAddr (addr 8, read-only).
  - On a taken exception whose ExcCode is 4 or 5 (AdEL/AdES), BadVAddr <= badvaddr_in. On any other trap, BadVAddr holds.
  - When the faulting instruction is itself the fetch (vpc misaligned, ExcCode 4 with exc from F), the top level supplies vpc on badvaddr_in.
  - Reset value 0.
- Undefined: no port and no register; addr 8 reads 0.

Decomposition:
- Shared package/header: register-number constants SR=12, CAUSE=13, EPC=14, PRID=15, BADVADDR=8.
- Also in the package: ExcCode constants INT=0, ADEL=4, ADES=5, RI=10, OV=12, and the field bit positions above.
- No sub-module. This is a single module of about 150-250 lines of RTL.

Test Plan:
- Reset, then mfc0 of 12, 13, 14, 15 -> 0, 0, 0, PRID. req=0.
- SR=0x0000_0401 (IM0, IE); hw_int=6'b000001; vpc=0x3010 -> req=1 that cycle. Next cycle: EXL=1, Cause.ExcCode=0, EPC=0x3010, Cause.IP[10]=1.
- exc_code_in=12, bd_in=1, vpc=0x3024, EXL=0 -> req=1, EPC=0x3020, Cause=0x8000_0030 (with IP=0).
- With EXL=1, exc_code_in=5 -> req=0, EPC unchanged. Then eret -> EXL=0 next cycle, epc_out stable.
- Same cycle: we=1 to EPC with 0x5000, and a pending int -> req=1, EPC=vpc, not 0x5000. Same cycle: eret and exc_code_in=10 -> EXL stays 1, ExcCode=10.
- CP0_BADVADDR_EN: exc_code_in=4, badvaddr_in=0x1003 -> mfc0 8 returns 0x1003. A following OV trap leaves it at 0x1003.
